receiver_buffer: RTL and testbench

Receive-side counterpart of the UART byte path: accepts bytes from the UART receiver, assembles each group of four into a 32-bit big-endian word, and queues the words in a circular FIFO for the core to pop. It sits between the UART receiver and the core's input instruction path. It mirrors the transmit buffer's MSB-first byte order, so a word sent by the host arrives unchanged.

---
 rtl/receiver_buffer.sv | 124 ++++++++++++
 tb/tb_receiver_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/receiver_buffer.sv
// rtl/receiver_buffer.sv - packs received bytes MSB-first into 32-bit words queued in a circular FIFO
// Optional partial-word idle timeout enabled by RECEIVER_BUFFER_TIMEOUT_EN.
module receiver_buffer #(
  parameter int BUFFER_SIZE = 32
`ifdef RECEIVER_BUFFER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                           CLK,
  input  logic                           reset_n,
  input  logic [7:0]                     input_data,
  input  logic                           input_valid,
  input  logic                           pop,
  input  logic                           clear,
  output logic [31:0]                    output_data,
  output logic                           ready,
  output logic                           full,
  output logic [$clog2(BUFFER_SIZE):0]   count,
  output logic                           overrun,
  output logic                           timeout
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;

  logic [31:0]   r_buf [BUFFER_SIZE];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [23:0]   r_asm;
  logic [1:0]    r_bytes;
  logic          r_overrun;

  logic          w_expire;
  logic [1:0]    w_bytes;
  logic          w_pop;
  logic          w_word_done;
  logic          w_push;
  logic          w_drop;

`ifdef RECEIVER_BUFFER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle;
  logic          r_timeout;

  // Expiry is judged before the incoming byte, so a byte on the expiry cycle starts a fresh word.
  assign w_expire = (r_bytes != 2'd0) && (r_idle == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (input_valid || (r_bytes == 2'd0) || w_expire)
        r_idle <= '0;
      else
        r_idle <= r_idle + 1'b1;
      if (clear)
        r_timeout <= 1'b0;
      else if (w_expire)
        r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign w_bytes     = w_expire ? 2'd0 : r_bytes;
  assign w_pop       = pop && (r_count != '0);
  assign w_word_done = input_valid && (w_bytes == 2'd3);
  // A full FIFO still accepts a word when the head is popped on the same edge.
  assign w_push      = w_word_done && ((r_count != CW'(BUFFER_SIZE)) || pop);
  assign w_drop      = w_word_done && !w_push;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUFFER_SIZE; i++) r_buf[i] <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_asm     <= '0;
      r_bytes   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (input_valid) begin
        case (w_bytes)
          2'd0:    r_asm[23:16] <= input_data;
          2'd1:    r_asm[15:8]  <= input_data;
          2'd2:    r_asm[7:0]   <= input_data;
          default: ;
        endcase
        r_bytes <= w_bytes + 2'd1;
      end else begin
        r_bytes <= w_bytes;
      end

      if (w_push) begin
        r_buf[r_tail] <= {r_asm, input_data};
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop)
        r_head <= r_head + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      if (clear)
        r_overrun <= 1'b0;
      else if (w_drop)
        r_overrun <= 1'b1;
    end
  end

  assign output_data = r_buf[r_head];
  assign ready       = (r_count != '0);
  assign full        = (r_count == CW'(BUFFER_SIZE));
  assign count       = r_count;
  assign overrun     = r_overrun;
endmodule

// File: tb/tb_receiver_buffer.sv
// tb/tb_receiver_buffer.sv - directed bench with a queue-based word model for receiver_buffer
module tb_receiver_buffer;
  localparam int N = 32;
`ifdef RECEIVER_BUFFER_TIMEOUT_EN
  localparam int TO = 100;
`endif

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  input_data = 8'h00;
  logic        input_valid = 1'b0;
  logic        pop = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] output_data;
  logic        ready;
  logic        full;
  logic [5:0]  count;
  logic        overrun;
  logic        timeout;

  receiver_buffer #(
    .BUFFER_SIZE(N)
`ifdef RECEIVER_BUFFER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .input_data(input_data), .input_valid(input_valid),
    .pop(pop), .clear(clear), .output_data(output_data), .ready(ready), .full(full),
    .count(count), .overrun(overrun), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Word-level model: partial word as a shifted integer, FIFO as a queue.
  logic [31:0] mq[$];
  logic [31:0] m_part;
  int          m_nb;
  int          m_idle;
  bit          m_ovr;
  bit          m_to;
  bit          m_pop_ok;
  int          m_sz;

  always @(posedge CLK) begin
    if (!reset_n) begin
      mq.delete();
      m_part = 0; m_nb = 0; m_idle = 0; m_ovr = 0; m_to = 0;
    end else begin
      m_sz = mq.size();
      m_pop_ok = pop && (m_sz > 0);
`ifdef RECEIVER_BUFFER_TIMEOUT_EN
      if (m_nb != 0 && m_idle + 1 == TO) begin
        m_nb = 0;
        m_to = 1;
      end
`endif
      if (m_pop_ok) void'(mq.pop_front());
      if (input_valid) begin
        m_part = {m_part[23:0], input_data};
        m_nb++;
        m_idle = 0;
        if (m_nb == 4) begin
          m_nb = 0;
          if (m_sz < N || m_pop_ok) mq.push_back(m_part);
          else m_ovr = 1;
        end
      end else if (m_nb != 0) begin
        m_idle++;
      end else begin
        m_idle = 0;
      end
      if (clear) begin
        m_ovr = 0;
        m_to = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (reset_n) begin
      check("ready", {31'd0, ready}, {31'd0, mq.size() != 0});
      check("full", {31'd0, full}, {31'd0, mq.size() == N});
      check("count", 32'(count), 32'(mq.size()));
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      check("timeout", {31'd0, timeout}, {31'd0, m_to});
      if (mq.size() != 0) check("head", output_data, mq[0]);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic p, input logic c);
    @(negedge CLK);
    input_valid = v; input_data = d; pop = p; clear = c;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic p_last);
    drive(1'b1, w[31:24], 1'b0, 1'b0);
    drive(1'b1, w[23:16], 1'b0, 1'b0);
    drive(1'b1, w[15:8],  1'b0, 1'b0);
    drive(1'b1, w[7:0],   p_last, 1'b0);
  endtask

  function automatic logic [31:0] pat(input int s, input int i);
    return {8'(i + s), 8'(8'h3C ^ 8'(i * 7)), 8'(255 - i), 8'(i * 13 + 1)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_data", output_data, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    reset_n = 1'b1;

    send_word(32'h12345678, 1'b0);
    idle();
    check("first_word", output_data, 32'h12345678);
    check("first_count", 32'(count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check("pop_empty", {31'd0, ready}, 32'd0);

    for (int i = 0; i < N; i++) send_word(pat(0, i), 1'b0);
    idle();
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", 32'(count), 32'd32);
    send_word(32'hDEADBEEF, 1'b0);
    idle();
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_count", 32'(count), 32'd32);
    check("ovr_head", output_data, pat(0, 0));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    check("ovr_clear", {31'd0, overrun}, 32'd0);

    send_word(32'hCAFEF00D, 1'b1);
    idle();
    check("fullpop_count", 32'(count), 32'd32);
    check("fullpop_ovr", {31'd0, overrun}, 32'd0);
    check("fullpop_head", output_data, pat(0, 1));

    repeat (N) drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check("drained", {31'd0, ready}, 32'd0);

    for (int w = 0; w < 80; w++)
      for (int b = 0; b < 4; b++)
        drive(1'b1, 8'(pat(100, w) >> (8 * (3 - b))), (b == 2) && (w > 0), 1'b0);
    idle();
    check("stream_count", 32'(count), 32'd1);
    check("stream_last", output_data, pat(100, 79));

    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(negedge CLK);
    input_valid = 1'b0; reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    send_word(32'hAABBCCDD, 1'b0);
    idle();
    check("rst_mid_word", output_data, 32'hAABBCCDD);
    check("rst_mid_count", 32'(count), 32'd1);

`ifdef RECEIVER_BUFFER_TIMEOUT_EN
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    repeat (99) idle();
    idle();
    check("to_before", {31'd0, timeout}, 32'd0);
    idle();
    check("to_set", {31'd0, timeout}, 32'd1);
    send_word(32'h01020304, 1'b0);
    idle();
    check("to_realign", output_data, 32'h01020304);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    check("to_clear", {31'd0, timeout}, 32'd0);
`endif

    repeat (2) idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
